seg_adder_arbiter: RTL and testbench
====================================

# seg_adder_arbiter

Round-robin arbiter and sequencer sharing one segmented carry-chain adder among NREQ requesters. A granted request is added over WIDTH/SEG_W cycles, one SEG_W-bit segment per cycle, with the inter-segment carry held in a flip-flop so the physical carry chain never exceeds SEG_W adder_carry cells. The block sits between requesting datapath clients and the fabric carry chain, and returns sum, carry-out and requester ID through a valid/ready response port.

## Interface
- WIDTH, 16: operand and sum width; must be an integer multiple of SEG_W.
- SEG_W, 8: segment width, i.e. the carry-chain length per cycle; NSEG = WIDTH/SEG_W, and NSEG = 1 is legal.
- NREQ, 4: number of requesters, at least 2; IDW = clog2(NREQ).

Ports:
- C, input, 1: clock; all state updates on the rising edge.
- R, input, 1: reset, synchronous, active-low.
- req_valid, input, NREQ: per-requester request valid.
- req_ready, output, NREQ: one-hot grant/accept.
- req_a, input, NREQ*WIDTH: operand A; requester i owns slice [i*WIDTH +: WIDTH].
- req_b, input, NREQ*WIDTH: operand B, sliced the same way as req_a.
- req_cin, input, NREQ: carry-in per requester.
- rsp_valid, output, 1: result valid.
- rsp_ready, input, 1: downstream accepts result.
- rsp_sum, output, WIDTH: A+B+cin, truncated to WIDTH bits.
- rsp_cout, output, 1: carry out of bit WIDTH-1.
- rsp_id, output, IDW: index of the requester that produced the result.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - req_ready is one-hot to the round-robin winner among asserted req_valid, searching from ptr upward with modulo NREQ wrap. It is all-zero if no request is valid.
  - On the accepting edge (req_valid[w] & req_ready[w]), latch A, B, cin and id=w into internal registers, then set carry_q=cin, seg=0, ptr=(w+1) mod NREQ, and enter ADD.
- ADD:
  - Each cycle, segment seg is computed: {carry_q, sum_q[seg*SEG_W +: SEG_W]} <= A_seg + B_seg + carry_q, using p=a^b, g=a&b and a rippled carry.
  - seg increments each cycle. After segment NSEG-1 the FSM enters DONE; the final carry becomes rsp_cout.
  - req_ready is all-zero.
- DONE:
  - rsp_valid=1 while rsp_sum, rsp_cout and rsp_id hold stable.
  - When rsp_ready=1, the FSM returns to IDLE on that edge. No new request is accepted in that same cycle.
  - req_ready is all-zero.
- Requesters may deassert req_valid before a grant without penalty. The operand slices of requester w need only be valid during the cycle its req_ready is high.
- ptr advances only on an acceptance. Non-requesting indices are skipped.
- Arithmetic is unsigned modulo 2^WIDTH. rsp_cout captures overflow, including the case A=2^WIDTH-1, B=0, cin=1.
- Reset (R=0 at an edge), in any state including mid-ADD or DONE:
  - The FSM goes to IDLE and ptr to 0.
  - seg, carry_q, sum_q and id are cleared to 0.
  - Any in-flight operation is discarded with no response.
  - While R=0, req_ready is forced to all-zero.

## Timing
- Reset values: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, req_ready=0 (combinational, gated by state==IDLE and R).
- Acceptance at edge k gives rsp_valid=1 from edge k+NSEG onward. With the defaults (NSEG=2), rsp_valid is first high in the cycle after edge k+2.
- Minimum initiation interval is NSEG+2 cycles per operation: 1 IDLE, NSEG ADD, and 1 DONE cycle when rsp_ready is already high.
- rsp_* outputs are registered and change only on ADD→DONE or on reset.
- With rsp_ready low, the FSM stays in DONE indefinitely and outputs remain bit-stable.
- req_ready depends combinationally on req_valid and registered state only. No path exists from rsp_ready to req_ready.

## Test plan
1. Single request, defaults: requester 0 with a=0x00FF, b=0x0001, cin=0 → rsp_sum=0x0100, rsp_cout=0, rsp_id=0, rsp_valid 2 edges after acceptance. This exercises the inter-segment carry.
2. Overflow: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
3. Fairness: all four req_valid held high with rsp_ready=1 → grants in order 0,1,2,3,0,1, one grant every 4 cycles. Each rsp_id matches its grant.
4. Skip and wrap: ptr=1 with only requesters 0 and 2 valid → grant 2 first, then 0, after which ptr=1.
5. Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid stays 1, data and ID are stable, req_ready stays all-zero. Raising rsp_ready → IDLE at the next edge.
6. Reset mid-op: drive R=0 for 1 cycle while seg=1 of an ADD → after the edge, rsp_valid=0 and ptr=0, and no response for the discarded request ever appears. A new request from requester 3 then completes normally with rsp_id=3.

Source files
------------

// File: rtl/seg_adder_arbiter.sv
// Round-robin arbiter feeding one shared segmented adder: a granted A+B+cin is
// summed SEG_W bits per cycle with the inter-segment carry held in a flop.
module seg_adder_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int SEG_W = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                   C,
  input  logic                   R,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic [IDW-1:0]         rsp_id
);

  localparam int NSEG   = WIDTH / SEG_W;
  localparam int SEGIW  = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDW-1:0]     r_ptr, r_id, r_rsp_id, w_win, w_cand;
  logic               w_found, w_accept;
  logic [WIDTH-1:0]   r_a, r_b, r_sum, r_rsp_sum, w_sum_nxt;
  logic               r_carry, r_rsp_cout;
  logic [SEGIW-1:0]   r_seg;
  logic               w_last;
  logic [SEG_W-1:0]   w_sa, w_sb, w_p, w_g, w_s;
  logic [SEG_W:0]     w_cy;

  // Winner search starts at r_ptr and wraps modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = IDW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_accept = w_found && (r_state == IDLE) && R;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win] = 1'b1;
  end

  assign w_sa   = r_a[r_seg*SEG_W +: SEG_W];
  assign w_sb   = r_b[r_seg*SEG_W +: SEG_W];
  assign w_last = (32'(r_seg) == NSEG - 1);

  always_comb begin
    w_p     = w_sa ^ w_sb;
    w_g     = w_sa & w_sb;
    w_s     = '0;
    w_cy    = '0;
    w_cy[0] = r_carry;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      w_s[i]    = w_p[i] ^ w_cy[i];
      w_cy[i+1] = w_g[i] | (w_p[i] & w_cy[i]);
    end
  end

  always_comb begin
    w_sum_nxt = r_sum;
    w_sum_nxt[r_seg*SEG_W +: SEG_W] = w_s;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ADD;
      ADD:     if (w_last) w_state_nxt = DONE;
      DONE:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (!R) r_state <= IDLE;
    else    r_state <= w_state_nxt;
  end

  // Result registers load only on the final segment so rsp_* stay frozen during ADD.
  always_ff @(posedge C) begin
    if (!R) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_seg      <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_id   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= req_a[w_win*WIDTH +: WIDTH];
            r_b     <= req_b[w_win*WIDTH +: WIDTH];
            r_carry <= req_cin[w_win];
            r_id    <= w_win;
            r_seg   <= '0;
            r_ptr   <= IDW'((32'(w_win) + 1) % NREQ);
          end
        end
        ADD: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_cy[SEG_W];
          r_seg   <= r_seg + 1'b1;
          if (w_last) begin
            r_rsp_sum  <= w_sum_nxt;
            r_rsp_cout <= w_cy[SEG_W];
            r_rsp_id   <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_seg_adder_arbiter.sv
// Directed bench for seg_adder_arbiter at default parameters (16-bit, 2 segments, 4 requesters).
module tb_seg_adder_arbiter;

  localparam int WIDTH = 16;
  localparam int SEG_W = 8;
  localparam int NREQ  = 4;

  logic              C = 1'b0;
  logic              R;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [WIDTH-1:0]  rsp_sum;
  logic [1:0]        rsp_id;

  int total = 0;
  int bad   = 0;

  seg_adder_arbiter #(.WIDTH(WIDTH), .SEG_W(SEG_W), .NREQ(NREQ)) dut (
    .C(C), .R(R),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 C = ~C;

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  // Called at posedge+1 just after an accepting edge; reports edges until rsp_valid.
  task automatic wait_valid(input int maxc, output int ncyc, output bit got);
    got  = 1'b0;
    ncyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge C); #1;
      if (rsp_valid) begin
        got  = 1'b1;
        ncyc = i + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    R = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = '0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_forced got=%b exp=0000", req_ready); end
    @(posedge C); #1;
    @(posedge C); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", rsp_sum); end
    total++; if (rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin bad++; $display("FAIL reset_cout_id got=%b/%0d exp=0/0", rsp_cout, rsp_id); end
    R = 1'b1; req_valid = 4'h0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_no_req got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single();
    int n; bit got;
    rsp_ready = 1'b1;
    set_op(0, 16'h00FF, 16'h0001, 1'b0);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(posedge C); #1;
    req_valid = 4'b0000;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_add got=%b exp=0000", req_ready); end
    wait_valid(8, n, got);
    total++; if (!got || n != 2) begin bad++; $display("FAIL single_latency got=%0d/%0d exp=1/2", got, n); end
    total++; if (rsp_sum !== 16'h0100) begin bad++; $display("FAIL single_sum got=%h exp=0100", rsp_sum); end
    total++; if (rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin bad++; $display("FAIL single_cout_id got=%b/%0d exp=0/0", rsp_cout, rsp_id); end
    @(posedge C); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_return got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_overflow();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] es [3];
    logic        ec [3];
    int n; bit got;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
    va[1] = 16'hFFFF; vb[1] = 16'h0000; vc[1] = 1'b1; es[1] = 16'h0000; ec[1] = 1'b1;
    va[2] = 16'h1234; vb[2] = 16'h4321; vc[2] = 1'b1; es[2] = 16'h5556; ec[2] = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(1, va[k], vb[k], vc[k]);
      req_valid = 4'b0010;
      #1;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL ovf%0d_grant got=%b exp=0010", k, req_ready); end
      @(posedge C); #1;
      req_valid = 4'b0000;
      wait_valid(8, n, got);
      total++; if (!got || n != 2) begin bad++; $display("FAIL ovf%0d_latency got=%0d/%0d exp=1/2", k, got, n); end
      total++; if (rsp_sum !== es[k] || rsp_cout !== ec[k] || rsp_id !== 2'd1) begin
        bad++; $display("FAIL ovf%0d_result got=%h/%b/%0d exp=%h/%b/1", k, rsp_sum, rsp_cout, rsp_id, es[k], ec[k]);
      end
      @(posedge C); #1;
    end
  endtask

  task automatic test_fairness();
    logic [15:0] es [4];
    int g;
    R = 1'b0; req_valid = 4'h0;
    @(posedge C); #1;
    R = 1'b1;
    set_op(0, 16'h1111, 16'h0F0F, 1'b0); es[0] = 16'h2020;
    set_op(1, 16'h2222, 16'h0F0F, 1'b1); es[1] = 16'h3132;
    set_op(2, 16'h3333, 16'h0F0F, 1'b0); es[2] = 16'h4242;
    set_op(3, 16'h4444, 16'h0F0F, 1'b1); es[3] = 16'h5354;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      #1;
      total++; if (req_ready !== 4'(1 << g)) begin bad++; $display("FAIL fair%0d_grant got=%b exp=%b", n, req_ready, 4'(1 << g)); end
      @(posedge C); #1;
      total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin bad++; $display("FAIL fair%0d_busy got=%b/%b exp=0000/0", n, req_ready, rsp_valid); end
      @(posedge C); #1;
      @(posedge C); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_sum !== es[g] || rsp_cout !== 1'b0) begin
        bad++; $display("FAIL fair%0d_rsp got=%b/%0d/%h/%b exp=1/%0d/%h/0", n, rsp_valid, rsp_id, rsp_sum, rsp_cout, g, es[g]);
      end
      @(posedge C); #1;
    end
    req_valid = 4'h0;
  endtask

  // Enters with ptr=2; one op from requester 0 moves ptr to 1.
  task automatic test_skip_wrap();
    int exp_g [4];
    logic [15:0] es [4];
    exp_g[0] = 0; exp_g[1] = 2; exp_g[2] = 0; exp_g[3] = 2;
    es[0] = 16'h2020; es[2] = 16'h4242; es[1] = 16'h0; es[3] = 16'h0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++; if (req_ready !== 4'(1 << exp_g[n])) begin bad++; $display("FAIL skip%0d_grant got=%b exp=%b", n, req_ready, 4'(1 << exp_g[n])); end
      @(posedge C); #1;
      req_valid = 4'b0101;
      @(posedge C); #1;
      @(posedge C); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[n]) || rsp_sum !== es[exp_g[n]]) begin
        bad++; $display("FAIL skip%0d_rsp got=%b/%0d/%h exp=1/%0d/%h", n, rsp_valid, rsp_id, rsp_sum, exp_g[n], es[exp_g[n]]);
      end
      @(posedge C); #1;
    end
    req_valid = 4'h0;
  endtask

  // Enters with ptr=3.
  task automatic test_backpressure();
    int n; bit got;
    rsp_ready = 1'b0;
    set_op(3, 16'hF000, 16'h1234, 1'b1);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%b exp=1000", req_ready); end
    @(posedge C); #1;
    req_valid = 4'hF;
    wait_valid(8, n, got);
    total++; if (!got || n != 2) begin bad++; $display("FAIL bp_latency got=%0d/%0d exp=1/2", got, n); end
    for (int k = 0; k < 5; k++) begin
      @(posedge C); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0235 || rsp_cout !== 1'b1 || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%b/%0d/%b exp=1/0235/1/3/0000", k, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_path got=%b exp=0000", req_ready); end
    @(posedge C); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/0001", rsp_valid, req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_reset_midop();
    int n; bit got;
    rsp_ready = 1'b1;
    set_op(1, 16'hAAAA, 16'h5555, 1'b1);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b exp=0010", req_ready); end
    @(posedge C); #1;
    req_valid = 4'b0000;
    @(posedge C); #1;
    R = 1'b0;
    @(posedge C); #1;
    R = 1'b1;
    total++; if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      bad++; $display("FAIL rmid_cleared got=%b/%h/%b/%0d exp=0/0000/0/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    wait_valid(6, n, got);
    total++; if (got) begin bad++; $display("FAIL rmid_ghost got=1 exp=0 after=%0d", n); end
    req_valid = 4'b1010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_ptr0 got=%b exp=0010", req_ready); end
    set_op(3, 16'h8000, 16'h8000, 1'b1);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rmid_grant3 got=%b exp=1000", req_ready); end
    @(posedge C); #1;
    req_valid = 4'b0000;
    wait_valid(8, n, got);
    total++; if (!got || n != 2) begin bad++; $display("FAIL rmid_latency got=%0d/%0d exp=1/2", got, n); end
    total++; if (rsp_sum !== 16'h0001 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin
      bad++; $display("FAIL rmid_result got=%h/%b/%0d exp=0001/1/3", rsp_sum, rsp_cout, rsp_id);
    end
    @(posedge C); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_skip_wrap();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
